// File: rtl/mem_ctrl.sv
// mem_ctrl: word RAM, UART TX with 4-byte FIFO and cycle counter behind rd_en/rd_valid handshake
module mem_ctrl #(
  parameter int    RAM_WORDS = 1024,
  parameter int    READ_WAIT = 0,
  parameter int    CLK_DIV   = 104,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [15:0] i_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        uart_tx,
  output logic        bus_fault
);
  localparam int AW = RAM_WORDS > 1 ? $clog2(RAM_WORDS) : 1;
  localparam int WW = READ_WAIT > 1 ? $clog2(READ_WAIT) : 1;
  localparam int BW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [15:0] UART_DATA   = 16'h8000;
  localparam logic [15:0] UART_STATUS = 16'h8004;
  localparam logic [15:0] CYCLE       = 16'h8008;
  localparam logic [16:0] RAM_END     = 17'(RAM_WORDS * 4);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  rd_state_t     rd_state;
  tx_state_t     tx_state;
  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo [4];
  logic [15:0]   wa, addr_q, ra;
  logic [31:0]   cyc, rdat;
  logic [WW-1:0] wcnt;
  logic [BW-1:0] bcnt;
  logic [2:0]    bidx, cnt;
  logic [1:0]    wp, rp;
  logic [7:0]    sh;
  logic          overrun, full, empty, busy, start, wr_ok, push_ok, pop, bit_done;

  function automatic logic is_ram(input logic [15:0] a);
    return {1'b0, a} < RAM_END;
  endfunction

  function automatic logic mapped(input logic [15:0] a);
    return is_ram(a) || a == UART_DATA || a == UART_STATUS || a == CYCLE;
  endfunction

  assign wa       = i_addr & 16'hFFFC;
  assign start    = rd_en && !wr_en && rd_state != R_WAIT;
  assign wr_ok    = wr_en && !rd_en;
  assign full     = cnt == 3'd4;
  assign empty    = cnt == 3'd0;
  assign busy     = tx_state != T_IDLE;
  assign bit_done = bcnt == BW'(CLK_DIV - 1);
  assign push_ok  = wr_ok && wa == UART_DATA && !full;
  assign pop      = tx_state == T_IDLE && !empty;

  always_comb begin
    ra   = rd_state == R_WAIT ? addr_q : wa;
    rdat = is_ram(ra) ? ram[ra[AW+1:2]] :
           ra == UART_STATUS ? {28'b0, busy, overrun, empty, full} :
           ra == CYCLE ? cyc : 32'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      rd_valid <= 1'b0;
      rd_data  <= 32'b0;
      addr_q   <= 16'b0;
      wcnt     <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_state == R_WAIT) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == WW'(READ_WAIT - 1)) begin
          rd_state <= R_RESP;
          rd_valid <= 1'b1;
          rd_data  <= rdat;
        end
      end else if (start) begin
        addr_q <= wa;
        wcnt   <= '0;
        if (READ_WAIT == 0) begin
          rd_state <= R_RESP;
          rd_valid <= 1'b1;
          rd_data  <= rdat;
        end else begin
          rd_state <= R_WAIT;
        end
      end else begin
        rd_state <= R_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_fault <= 1'b0;
      cyc       <= 32'b0;
    end else begin
      cyc <= cyc + 1'b1;
      if ((rd_en && wr_en) || (wr_en && !mapped(wa)) || (start && !mapped(wa)))
        bus_fault <= 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (wr_ok && is_ram(wa)) ram[wa[AW+1:2]] <= wr_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= 3'd0;
      wp       <= 2'd0;
      rp       <= 2'd0;
      overrun  <= 1'b0;
      tx_state <= T_IDLE;
      uart_tx  <= 1'b1;
      bcnt     <= '0;
      bidx     <= 3'd0;
      sh       <= 8'b0;
    end else begin
      if (wr_ok && wa == UART_DATA && full)
        overrun <= 1'b1;
      else if (wr_ok && wa == UART_STATUS && wr_data[2])
        overrun <= 1'b0;
      if (push_ok) begin
        fifo[wp] <= wr_data[7:0];
        wp       <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt  <= cnt + {2'b0, push_ok} - {2'b0, pop};
      bcnt <= (tx_state == T_IDLE || bit_done) ? '0 : bcnt + 1'b1;
      case (tx_state)
        T_IDLE: if (pop) begin
          sh       <= fifo[rp];
          uart_tx  <= 1'b0;
          tx_state <= T_START;
        end
        T_START: if (bit_done) begin
          uart_tx  <= sh[0];
          bidx     <= 3'd0;
          tx_state <= T_DATA;
        end
        T_DATA: if (bit_done) begin
          sh      <= sh >> 1;
          bidx    <= bidx + 1'b1;
          uart_tx <= bidx == 3'd7 ? 1'b1 : sh[1];
          if (bidx == 3'd7) tx_state <= T_STOP;
        end
        T_STOP: if (bit_done) tx_state <= T_IDLE;
        default: tx_state <= T_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized RAM traffic against an array model, UART frames decoded
// from the serial line, plus directed fault/reset/wait-state checks.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, rd_en, wr_en, rd_valid, uart_tx, bus_fault;
    logic [15:0] i_addr;
    logic [31:0] wr_data, rd_data;
    logic        rst_n2, rd_en2, wr_en2, rd_valid2, uart_tx2, bus_fault2;
    logic [15:0] i_addr2;
    logic [31:0] wr_data2, rd_data2;
    int          n = 0, errs = 0;
    logic [31:0] mdl [32];
    logic [7:0]  exp_q[$], rx_q[$];

    always #5 clk = ~clk;

    mem_ctrl #(.READ_WAIT(0), .CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .i_addr(i_addr), .wr_en(wr_en),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .uart_tx(uart_tx),
        .bus_fault(bus_fault));

    mem_ctrl #(.READ_WAIT(2), .CLK_DIV(4)) dut2 (
        .clk(clk), .rst_n(rst_n2), .rd_en(rd_en2), .i_addr(i_addr2), .wr_en(wr_en2),
        .wr_data(wr_data2), .rd_data(rd_data2), .rd_valid(rd_valid2), .uart_tx(uart_tx2),
        .bus_fault(bus_fault2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        i_addr = a; wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        i_addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("rd_valid", {31'b0, rd_valid}, 32'd1);
        d = rd_data;
        @(negedge clk);
        check("rd_pulse", {31'b0, rd_valid}, 32'd0);
    endtask

    function automatic logic [15:0] slot_addr(input int s);
        return 16'(s * 128 + 12 + $urandom_range(0, 3));
    endfunction

    task automatic wait_start(input string tag);
        int w;
        w = 0;
        while (uart_tx !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check(tag, {31'b0, w < 20}, 32'd1);
    endtask

    // Serial decoder: samples each bit near its middle
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clk);
                check("rx_stop", {31'b0, uart_tx}, 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          op, s, lat;
        logic [31:0] d, c1, c2;
        logic [9:0]  fr;
        int          sl [3];
        rst_n = 0; rst_n2 = 0; rd_en = 0; wr_en = 0; i_addr = 0; wr_data = 0;
        rd_en2 = 0; wr_en2 = 0; i_addr2 = 0; wr_data2 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1; rst_n2 = 1;
        check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_fault", {31'b0, bus_fault}, 32'd0);
        rd(16'h8004, d); check("rst_status", d, 32'h2);
        rd(16'h8000, d); check("uart_data_rd", d, 32'h0);

        wr(16'h0010, 32'hDEADBEEF);
        rd(16'h0012, d); check("ram_deadbeef", d, 32'hDEADBEEF);

        for (int i = 0; i < 32; i++) begin
            mdl[i] = $urandom;
            wr(slot_addr(i), mdl[i]);
        end
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 2);
            s  = $urandom_range(0, 31);
            if (op == 0) begin
                mdl[s] = $urandom;
                wr(slot_addr(s), mdl[s]);
            end else if (op == 1) begin
                rd(slot_addr(s), d);
                check("ram_rand", d, mdl[s]);
            end else begin
                for (int k = 0; k < 3; k++) sl[k] = $urandom_range(0, 31);
                i_addr = slot_addr(sl[0]); rd_en = 1'b1;
                for (int k = 1; k < 3; k++) begin
                    @(negedge clk);
                    check("b2b_valid", {31'b0, rd_valid}, 32'd1);
                    check("b2b_data", rd_data, mdl[sl[k-1]]);
                    i_addr = slot_addr(sl[k]);
                end
                @(negedge clk);
                rd_en = 1'b0;
                check("b2b_valid", {31'b0, rd_valid}, 32'd1);
                check("b2b_data", rd_data, mdl[sl[2]]);
                @(negedge clk);
                check("b2b_end", {31'b0, rd_valid}, 32'd0);
            end
        end
        check("no_fault", {31'b0, bus_fault}, 32'd0);

        rd(16'h8008, c1);
        repeat (8) @(negedge clk);
        rd(16'h8008, c2);
        check("cycle_diff", c2 - c1, 32'd10);

        wr(16'h8000, 32'hFFFF_FF55);
        exp_q.push_back(8'h55);
        wait_start("tx_start_55");
        fr = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 40; k++) begin
            check("tx_bit", {31'b0, uart_tx}, {31'b0, fr[k/4]});
            @(negedge clk);
        end
        check("tx_idle", {31'b0, uart_tx}, 32'd1);

        wr(16'h8000, 32'h0000_00A3);
        exp_q.push_back(8'hA3);
        repeat (6) @(negedge clk);
        rd(16'h8004, d); check("status_busy", d, 32'hA);
        repeat (50) @(negedge clk);
        rd(16'h8004, d); check("status_done", d, 32'h2);

        for (int i = 0; i < 6; i++) begin
            wr(16'h8000, 32'(8'h11 * (i + 1)));
            if (i < 5) exp_q.push_back(8'(8'h11 * (i + 1)));
        end
        rd(16'h8004, d); check("status_overrun", d, 32'hD);
        wr(16'h8004, 32'h4);
        rd(16'h8004, d); check("status_ovr_clr", d, 32'h9);
        repeat (260) @(negedge clk);
        rd(16'h8004, d); check("status_drained", d, 32'h2);
        check("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check("rx_byte", {24'b0, rx_q[i]}, {24'b0, exp_q[i]});

        i_addr = 16'h0010; wr_data = 32'h1234_5678; rd_en = 1'b1; wr_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        check("rdwr_fault", {31'b0, bus_fault}, 32'd1);
        check("rdwr_no_valid", {31'b0, rd_valid}, 32'd0);
        @(negedge clk);
        check("rdwr_no_valid2", {31'b0, rd_valid}, 32'd0);
        rd(16'h0010, d); check("rdwr_ram_kept", d, 32'hDEADBEEF);
        rd(16'h4000, d); check("unmapped_rd", d, 32'h0);
        check("fault_sticky", {31'b0, bus_fault}, 32'd1);

        wr(16'h8000, 32'h0);
        wait_start("tx_start_rst");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_frame_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_fault_clr", {31'b0, bus_fault}, 32'd0);
        rd(16'h8008, d); check("cycle_after_rst", {31'b0, d < 4}, 32'd1);
        rd(16'h8004, d); check("status_after_rst", d, 32'h2);

        i_addr2 = 16'h0080; wr_data2 = 32'hCAFE_0001; wr_en2 = 1'b1;
        @(negedge clk);
        wr_en2 = 1'b0; rd_en2 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rd_valid2 && lat < 10);
        rd_en2 = 1'b0;
        check("wait_latency", lat, 3);
        check("wait_data", rd_data2, 32'hCAFE_0001);
        @(negedge clk);
        check("wait_pulse", {31'b0, rd_valid2}, 32'd0);
        repeat (6) @(negedge clk);
        rd_en2 = 1'b1;
        @(negedge clk);
        rd_en2 = 1'b0; rst_n2 = 1'b0;
        @(negedge clk);
        rst_n2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("abort_no_valid", {31'b0, rd_valid2}, 32'd0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: RAM_WORDS, 1024, word-addressed RAM depth; READ_WAIT, 0, extra wait cycles per read; CLK_DIV, 104, clocks per UART bit; INIT_FILE, "", RAM preload image (empty = none).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-004 rd_en  in  1  read request from cpu, held until rd_valid.
REQ-005 i_addr  in  16  byte address from cpu, word aligned, bits[1:0] ignored.
REQ-006 wr_en  in  1  single-cycle write strobe from cpu, no response.
REQ-007 wr_data  in  32  write data.
REQ-008 rd_data  out  32  registered read data, valid only when rd_valid=1.
REQ-009 rd_valid  out  1  one-cycle read completion pulse.
REQ-010 uart_tx  out  1  serial 8N1 output, idle high.
REQ-011 bus_fault  out  1  sticky protocol/decode fault flag.

Function
REQ-012 Address map SHALL be: 0x0000-(RAM_WORDS*4-1) RAM, index i_addr[11:2]; 0x8000 UART_DATA; 0x8004 UART_STATUS; 0x8008 CYCLE; all others unmapped.
REQ-013 Read FSM SHALL have states IDLE, WAIT, RESP; IDLE + rd_en -> capture address, go WAIT (READ_WAIT>0) or RESP (READ_WAIT=0).
REQ-014 WAIT SHALL count READ_WAIT cycles with i_addr/rd_en ignored, then go RESP.
REQ-015 RESP SHALL drive rd_valid=1 and rd_data for exactly one cycle; if rd_en=1 in that cycle, the new i_addr is captured (back-to-back), else return to IDLE.
REQ-016 With READ_WAIT=0, rd_en held for N cycles SHALL produce rd_valid in cycles 2..N+1, each returning data for the address presented one cycle earlier.
REQ-017 RAM write: wr_en=1 to RAM region SHALL write the full 32-bit wr_data at that clock edge; a read of the same word in the next cycle returns the new value.
REQ-018 Read data: RAM word; UART_DATA reads 0; UART_STATUS = {28'b0, tx_busy, overrun, fifo_empty, fifo_full} (bit3..bit0); CYCLE = free-running 32-bit counter, wraps 0xFFFFFFFF->0.
REQ-019 UART_DATA write SHALL push wr_data[7:0] into a 4-entry TX FIFO; push while full (evaluated before any same-cycle pop) is dropped and sets overrun.
REQ-020 UART_STATUS write with wr_data[2]=1 SHALL clear overrun; other bits read-only.
REQ-021 UART TX FSM states IDLE, START, DATA, STOP: IDLE + FIFO non-empty -> pop, START; each state bit lasts CLK_DIV cycles; DATA sends 8 bits LSB first; STOP -> IDLE; frame = 10*CLK_DIV cycles.
REQ-022 tx_busy SHALL be 1 in START, DATA, STOP; a next byte starts the cycle after STOP completes if FIFO non-empty.
REQ-023 rd_en=1 and wr_en=1 together SHALL set bus_fault, suppress the write and not start a read.
REQ-024 Read or write to an unmapped address SHALL set bus_fault; reads still complete with rd_data=0, writes ignored.
REQ-025 bus_fault SHALL remain set until reset.

Reset
REQ-026 rst_n=0 at an edge SHALL set: rd_valid=0, rd_data=0, read FSM IDLE, FIFO empty, overrun=0, TX FSM IDLE, uart_tx=1, CYCLE=0, bus_fault=0.
REQ-027 Reset mid-read SHALL abort with no rd_valid; reset mid-frame SHALL abandon the byte and drive uart_tx=1 next cycle.
REQ-028 RAM contents SHALL NOT be affected by reset; INIT_FILE preload applies at configuration only.

Verification
REQ-029 Write 0xDEADBEEF to 0x0010, then rd_en at 0x0010 -> rd_valid next cycle, rd_data=0xDEADBEEF.
REQ-030 READ_WAIT=2, rd_en at 0x0080 held -> rd_valid exactly 3 cycles after request, single-cycle pulse.
REQ-031 Write 0x55 to 0x8000, CLK_DIV=4 -> uart_tx low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high; STATUS bit3=1 during frame.
REQ-032 Six back-to-back writes to 0x8000 while idle -> STATUS overrun=1, fifo_full=1; write 0x4 to 0x8004 -> overrun=0; exactly 5 bytes transmitted.
REQ-033 rd_en=1 and wr_en=1 at 0x0010 -> bus_fault=1, RAM word unchanged, no rd_valid; read at 0x4000 -> rd_data=0, bus_fault=1 until rst_n=0.
REQ-034 Read CYCLE twice 10 cycles apart -> difference 10; reset -> next read returns a value under 4.
